// File: rtl/mips_controller_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, funct codes,
// ALU operation codes and FSM state encodings.
package mips_defs;

  localparam int OPBITS_DEF    = 6;
  localparam int FUNCTBITS_DEF = 6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_ONE    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // Encoding 4'd15 is intentionally unused and recovers to S_FETCH1.
  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

endpackage

// File: rtl/mips_controller_if.sv
// Control/status bundle between the multicycle controller (master) and the
// 8-bit datapath (slave).
interface mips_controller_if #(
  parameter int OPBITS    = 6,
  parameter int FUNCTBITS = 6
);
  logic [OPBITS-1:0]    op;
  logic [FUNCTBITS-1:0] funct;
  logic                 zero;

  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic       memtoreg;
  logic       iord;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic [1:0] pcsource;
  logic [1:0] alusrcb;
  logic [3:0] irwrite;
  logic [2:0] alucont;

  modport master (
    input  op, funct, zero,
    output memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
           regdst, pcsource, alusrcb, irwrite, alucont
  );

  modport slave (
    output op, funct, zero,
    input  memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
           regdst, pcsource, alusrcb, irwrite, alucont
  );
endinterface

// File: rtl/mips_controller_alu_decoder.sv
// Combinational ALU control: aluop selects add/sub directly or defers to funct.
module alu_decoder
  import mips_defs::*;
#(
  parameter int FUNCTBITS = 6
) (
  input  logic [1:0]           aluop,
  input  logic [FUNCTBITS-1:0] funct,
  output logic [2:0]           alucont
);

  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucont = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucont = ALU_ADD;
          F_SUB:   alucont = ALU_SUB;
          F_AND:   alucont = ALU_AND;
          F_OR:    alucont = ALU_OR;
          F_SLT:   alucont = ALU_SLT;
          default: alucont = ALU_ADD;
        endcase
      end
      default: alucont = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit MIPS datapath: four byte fetches, decode,
// then per-opcode execute/memory/write-back states.
//
// state    | meaning
// FETCH1-4 | read instruction byte n into IR lane n, PC += 1
// DECODE   | precompute branch target
// MEMADR   | compute load/store address
// LBRD     | read data memory
// LBWR     | write loaded byte to rt
// SBWR     | write register byte to memory
// RTYPEEX  | ALU op from funct
// RTYPEWR  | write ALU result to rd
// BEQEX    | compare, load PC with target if equal
// JEX      | load PC with jump address
// ADDIEX   | add immediate
// ADDIWR   | write sum to rt
module mips_controller
  import mips_defs::*;
#(
  parameter int OPBITS    = 6,
  parameter int FUNCTBITS = 6
) (
  input logic              clk,
  input logic              reset,
  mips_controller_if.master bus
);

  state_t state, next_state;

  logic [OPBITS-1:0]    op;
  logic [FUNCTBITS-1:0] funct;

  logic       memread_s, memwrite_s, alusrca_s, memtoreg_s, iord_s;
  logic       regwrite_s, regdst_s, pcwrite_s, pcwritecond_s;
  logic [1:0] pcsource_s, alusrcb_s, aluop_s;
  logic [3:0] irwrite_s;
  logic [2:0] alucont_s;

  assign op    = bus.op;
  assign funct = bus.funct;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH1;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = S_FETCH1;
    memread_s     = 1'b0;
    memwrite_s    = 1'b0;
    alusrca_s     = 1'b0;
    memtoreg_s    = 1'b0;
    iord_s        = 1'b0;
    regwrite_s    = 1'b0;
    regdst_s      = 1'b0;
    pcwrite_s     = 1'b0;
    pcwritecond_s = 1'b0;
    pcsource_s    = PCSRC_ALU;
    alusrcb_s     = SRCB_REG;
    aluop_s       = ALUOP_ADD;
    irwrite_s     = 4'b0000;

    case (state)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        memread_s  = 1'b1;
        alusrcb_s  = SRCB_ONE;
        pcsource_s = PCSRC_ALU;
        pcwrite_s  = 1'b1;
        case (state)
          S_FETCH1: begin irwrite_s = 4'b0001; next_state = S_FETCH2; end
          S_FETCH2: begin irwrite_s = 4'b0010; next_state = S_FETCH3; end
          S_FETCH3: begin irwrite_s = 4'b0100; next_state = S_FETCH4; end
          default:  begin irwrite_s = 4'b1000; next_state = S_DECODE; end
        endcase
      end
      S_DECODE: begin
        alusrcb_s = SRCB_BRANCH;
        case (op)
          OP_LB, OP_SB: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_RTYPEEX;
          OP_BEQ:       next_state = S_BEQEX;
          OP_J:         next_state = S_JEX;
          OP_ADDI:      next_state = S_ADDIEX;
          default:      next_state = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        alusrca_s  = 1'b1;
        alusrcb_s  = SRCB_IMM;
        next_state = (op == OP_LB) ? S_LBRD : S_SBWR;
      end
      S_LBRD: begin
        memread_s  = 1'b1;
        iord_s     = 1'b1;
        next_state = S_LBWR;
      end
      S_LBWR: begin
        regwrite_s = 1'b1;
        memtoreg_s = 1'b1;
      end
      S_SBWR: begin
        memwrite_s = 1'b1;
        iord_s     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca_s  = 1'b1;
        aluop_s    = ALUOP_FUNCT;
        next_state = S_RTYPEWR;
      end
      S_RTYPEWR: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b1;
      end
      S_BEQEX: begin
        alusrca_s     = 1'b1;
        aluop_s       = ALUOP_SUB;
        pcwritecond_s = 1'b1;
        pcsource_s    = PCSRC_ALUOUT;
      end
      S_JEX: begin
        pcwrite_s  = 1'b1;
        pcsource_s = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        alusrca_s  = 1'b1;
        alusrcb_s  = SRCB_IMM;
        next_state = S_ADDIWR;
      end
      S_ADDIWR: begin
        regwrite_s = 1'b1;
        regdst_s   = 1'b0;
      end
      default: next_state = S_FETCH1;
    endcase
  end

  alu_decoder #(.FUNCTBITS(FUNCTBITS)) u_alu_decoder (
    .aluop   (aluop_s),
    .funct   (funct),
    .alucont (alucont_s)
  );

  // Write enables are gated by reset so nothing commits while it is held.
  assign bus.memwrite = memwrite_s & ~reset;
  assign bus.regwrite = regwrite_s & ~reset;
  assign bus.pcen     = (pcwrite_s | (pcwritecond_s & bus.zero)) & ~reset;
  assign bus.irwrite  = reset ? 4'b0000 : irwrite_s;

  assign bus.memread  = memread_s;
  assign bus.alusrca  = alusrca_s;
  assign bus.memtoreg = memtoreg_s;
  assign bus.iord     = iord_s;
  assign bus.regdst   = regdst_s;
  assign bus.pcsource = pcsource_s;
  assign bus.alusrcb  = alusrcb_s;
  assign bus.alucont  = alucont_s;

endmodule

// File: tb/tb_mips_controller.sv
// Self-checking bench: per-instruction expected output sequences are built from
// the opcode rules and compared cycle by cycle against the controller.
module tb_mips_controller;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       pcen;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [3:0] irwrite;
    logic [2:0] alucont;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  mips_controller_if #(.OPBITS(6), .FUNCTBITS(6)) bus ();

  mips_controller #(.OPBITS(6), .FUNCTBITS(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e = '0;
    e.alucont = 3'b010;
    return e;
  endfunction

  function automatic exp_t fetch(input int k);
    exp_t e;
    e = blank();
    e.memread = 1'b1;
    e.alusrcb = 2'b01;
    e.pcen    = 1'b1;
    e.irwrite = 4'b0001 << k;
    return e;
  endfunction

  function automatic exp_t under_reset(input exp_t e);
    exp_t r;
    r = e;
    r.memwrite = 1'b0;
    r.regwrite = 1'b0;
    r.pcen     = 1'b0;
    r.irwrite  = 4'b0000;
    return r;
  endfunction

  // Expected cycle-by-cycle outputs for one whole instruction.
  task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z,
                       output exp_t q[$]);
    exp_t e;
    q = {};
    for (int k = 0; k < 4; k++) q.push_back(fetch(k));
    e = blank(); e.alusrcb = 2'b11; q.push_back(e);
    if (o == 6'b100000 || o == 6'b101000) begin
      e = blank(); e.alusrca = 1'b1; e.alusrcb = 2'b10; q.push_back(e);
      if (o == 6'b100000) begin
        e = blank(); e.memread = 1'b1; e.iord = 1'b1; q.push_back(e);
        e = blank(); e.regwrite = 1'b1; e.memtoreg = 1'b1; q.push_back(e);
      end else begin
        e = blank(); e.memwrite = 1'b1; e.iord = 1'b1; q.push_back(e);
      end
    end else if (o == 6'b000000) begin
      e = blank(); e.alusrca = 1'b1; e.alucont = rtype_alu(f); q.push_back(e);
      e = blank(); e.regwrite = 1'b1; e.regdst = 1'b1; q.push_back(e);
    end else if (o == 6'b000100) begin
      e = blank(); e.alusrca = 1'b1; e.alucont = 3'b110; e.pcen = z;
      e.pcsource = 2'b01; q.push_back(e);
    end else if (o == 6'b000010) begin
      e = blank(); e.pcen = 1'b1; e.pcsource = 2'b10; q.push_back(e);
    end else if (o == 6'b001000) begin
      e = blank(); e.alusrca = 1'b1; e.alusrcb = 2'b10; q.push_back(e);
      e = blank(); e.regwrite = 1'b1; q.push_back(e);
    end
  endtask

  task automatic check(input exp_t e, input string tag);
    exp_t obs;
    #1;
    obs.memread  = bus.memread;
    obs.memwrite = bus.memwrite;
    obs.alusrca  = bus.alusrca;
    obs.memtoreg = bus.memtoreg;
    obs.iord     = bus.iord;
    obs.pcen     = bus.pcen;
    obs.regwrite = bus.regwrite;
    obs.regdst   = bus.regdst;
    obs.pcsource = bus.pcsource;
    obs.alusrcb  = bus.alusrcb;
    obs.irwrite  = bus.irwrite;
    obs.alucont  = bus.alucont;
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  // Starts at a negedge in FETCH1; stops after 'limit' cycles (0 = whole instruction).
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int limit, input string tag);
    exp_t q[$];
    build(o, f, z, q);
    bus.op = o; bus.funct = f; bus.zero = z;
    foreach (q[i]) begin
      if (limit != 0 && i >= limit) break;
      check(q[i], $sformatf("%s c%0d", tag, i + 1));
      @(negedge clk);
    end
  endtask

  initial begin
    exp_t e;
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [5:0] o, f;
    ops = '{6'b100000, 6'b101000, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1; bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check(under_reset(fetch(0)), "reset hold 1");
    @(negedge clk);
    check(under_reset(fetch(0)), "reset hold 2");
    reset = 1'b0;

    run_instr(6'b100000, 6'b000000, 1'b0, 0, "lb");
    run_instr(6'b000000, 6'b101010, 1'b0, 0, "rtype slt");
    run_instr(6'b000100, 6'b000000, 1'b1, 0, "beq taken");
    run_instr(6'b000100, 6'b000000, 1'b0, 0, "beq not taken");
    run_instr(6'b111111, 6'b000000, 1'b1, 0, "unknown op");
    run_instr(6'b101000, 6'b000000, 1'b0, 0, "sb");
    run_instr(6'b001000, 6'b000000, 1'b0, 0, "addi");
    run_instr(6'b000010, 6'b000000, 1'b0, 0, "j");

    // Reset asserted while in RTYPEEX aborts the instruction.
    run_instr(6'b000000, 6'b100010, 1'b0, 5, "rtype pre-reset");
    reset = 1'b1;
    e = blank(); e.alusrca = 1'b1; e.alucont = 3'b110;
    check(under_reset(e), "reset in rtypeex");
    @(negedge clk);
    check(under_reset(fetch(0)), "reset -> fetch1");
    reset = 1'b0;
    run_instr(6'b000000, 6'b100101, 1'b0, 0, "rtype after reset");

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 7) o = 6'($urandom);
      else o = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 1) == 1) f = fns[$urandom_range(0, 4)];
      else f = 6'($urandom);
      run_instr(o, f, 1'($urandom), 0, $sformatf("rand%0d op=%b fn=%b", n, o, f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
